// File: rtl/wb_pkg.sv
// Shared writeback-stage types: wbSel encodings, load funct3 codes, latch layout.
package wb_pkg;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10,
    WB_RSV = 2'b11
  } wb_sel_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Data driven to the register file for the reserved wbSel code.
  localparam logic [31:0] WB_RSV_DATA = 32'h0000_0000;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rd;
    logic        regWr;
    wb_sel_e     wbSel;
    logic [31:0] aluRes;
    logic [31:0] memData;
    logic [31:0] pcInc;
    logic [2:0]  funct3;
  } memwb_t;

endpackage

// File: rtl/load_extend.sv
// Picks the addressed byte/halfword out of a loaded word and extends it.
module load_extend
  import wb_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addrLo,
  input  logic [2:0]  funct3,
  output logic [31:0] value
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane select: bytes by both address bits, halfwords by addrLo[1] only.
  always_comb begin
    w_byte = 8'h00;
    case (addrLo)
      2'b00: w_byte = word[7:0];
      2'b01: w_byte = word[15:8];
      2'b10: w_byte = word[23:16];
      2'b11: w_byte = word[31:24];
      default: w_byte = 8'h00;
    endcase
    w_half = addrLo[1] ? word[31:16] : word[15:0];
  end

  // Extension by load type; unknown codes pass the word through.
  always_comb begin
    value = word;
    case (funct3)
      F3_LB:   value = {{24{w_byte[7]}}, w_byte};
      F3_LH:   value = {{16{w_half[15]}}, w_half};
      F3_LW:   value = word;
      F3_LBU:  value = {24'h0, w_byte};
      F3_LHU:  value = {16'h0, w_half};
      default: value = word;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB latch and writeback mux: register-file write port, bypass hits and
// retired-instruction counter. Outputs are combinational from the latch so
// they settle well before the negedge-sampling register file.
module wb_stage
  import wb_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [4:0]       in_rd,
  input  logic             in_regWr,
  input  logic [1:0]       in_wbSel,
  input  logic [31:0]      in_aluRes,
  input  logic [31:0]      in_memData,
  input  logic [31:0]      in_pcInc,
  input  logic [2:0]       in_funct3,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  output logic [4:0]       rd,
  output logic [31:0]      dataWr,
  output logic             ruWr,
  output logic             fwdA,
  output logic             fwdB,
  output logic [CNT_W-1:0] instret
);

  memwb_t            r_latch;
  memwb_t            w_next;
  logic [CNT_W-1:0]  r_instret;
  logic [31:0]       w_ldData;
  logic              w_retire;

  assign w_next = '{valid:   in_valid,
                    rd:      in_rd,
                    regWr:   in_regWr,
                    wbSel:   wb_sel_e'(in_wbSel),
                    aluRes:  in_aluRes,
                    memData: in_memData,
                    pcInc:   in_pcInc,
                    funct3:  in_funct3};

  // A valid latched instruction retires whenever the latch is overwritten,
  // including when it is squashed by flush.
  assign w_retire = r_latch.valid && (!stall || flush);

  // Latch update: reset > flush (bubble) > stall (hold) > capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_latch   <= '0;
      r_instret <= '0;
    end else begin
      if (flush)       r_latch.valid <= 1'b0;
      else if (!stall) r_latch       <= w_next;
      if (w_retire)    r_instret     <= r_instret + 1'b1;
    end
  end

  load_extend u_ld (
    .word   (r_latch.memData),
    .addrLo (r_latch.aluRes[1:0]),
    .funct3 (r_latch.funct3),
    .value  (w_ldData)
  );

  // Writeback data mux, write enable (x0 and reserved code suppressed), bypass.
  always_comb begin
    dataWr = WB_RSV_DATA;
    case (r_latch.wbSel)
      WB_ALU:  dataWr = r_latch.aluRes;
      WB_MEM:  dataWr = w_ldData;
      WB_PC4:  dataWr = r_latch.pcInc;
      default: dataWr = WB_RSV_DATA;
    endcase
    ruWr = r_latch.valid && r_latch.regWr && (r_latch.rd != 5'd0) &&
           (r_latch.wbSel != WB_RSV);
    fwdA = ruWr && (r_latch.rd == rs1);
    fwdB = ruWr && (r_latch.rd == rs2);
  end

  assign rd      = r_latch.rd;
  assign instret = r_instret;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage; small counter width so wrap is reachable.
module tb_wb_stage;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst, stall, flush, in_valid, in_regWr;
  logic [4:0]    in_rd, rs1, rs2;
  logic [1:0]    in_wbSel;
  logic [31:0]   in_aluRes, in_memData, in_pcInc;
  logic [2:0]    in_funct3;
  logic [4:0]    rd;
  logic [31:0]   dataWr;
  logic          ruWr, fwdA, fwdB;
  logic [CW-1:0] instret;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  wb_stage #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_rd(in_rd), .in_regWr(in_regWr),
    .in_wbSel(in_wbSel), .in_aluRes(in_aluRes), .in_memData(in_memData),
    .in_pcInc(in_pcInc), .in_funct3(in_funct3), .rs1(rs1), .rs2(rs2),
    .rd(rd), .dataWr(dataWr), .ruWr(ruWr), .fwdA(fwdA), .fwdB(fwdB),
    .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [4:0] d, input logic w,
                        input logic [1:0] sel, input logic [31:0] alu,
                        input logic [31:0] mem, input logic [31:0] pc,
                        input logic [2:0] f3);
    in_valid = v; in_rd = d; in_regWr = w; in_wbSel = sel;
    in_aluRes = alu; in_memData = mem; in_pcInc = pc; in_funct3 = f3;
  endtask

  task automatic test_reset();
    rst = 1; stall = 0; flush = 0; rs1 = 0; rs2 = 0;
    set_in(1, 5'd3, 1, 2'b00, 32'hDEAD_BEEF, 0, 0, 0);
    tick(); tick();
    checks++;
    if ({rd, dataWr, ruWr, fwdA, fwdB} !== 40'h0 || instret !== '0) begin
      errors++;
      $display("FAIL reset: rd=%0d data=%h ruWr=%b fwd=%b%b instret=%0d, want all 0",
               rd, dataWr, ruWr, fwdA, fwdB, instret);
    end
    rst = 0;
    exp_cnt = 0;
  endtask

  task automatic test_loads();
    // lb at byte 3 of 0x80FF_1234 -> 0x80 sign-extended
    set_in(1, 5'd5, 1, 2'b01, 32'h0000_1003, 32'h80FF_1234, 0, 3'b000);
    tick();
    checks++;
    if (dataWr !== 32'hFFFF_FF80 || ruWr !== 1'b1 || rd !== 5'd5 || instret !== CW'(exp_cnt)) begin
      errors++;
      $display("FAIL lb: data=%h ruWr=%b rd=%0d cnt=%0d, want ffffff80 1 5 %0d",
               dataWr, ruWr, rd, instret, exp_cnt);
    end
    // lhu upper half
    set_in(1, 5'd6, 1, 2'b01, 32'h0000_0002, 32'hBEEF_0001, 0, 3'b101);
    tick(); exp_cnt++;
    checks++;
    if (dataWr !== 32'h0000_BEEF || instret !== CW'(exp_cnt)) begin
      errors++;
      $display("FAIL lhu: data=%h cnt=%0d, want 0000beef %0d", dataWr, instret, exp_cnt);
    end
    // lh same lane
    set_in(1, 5'd6, 1, 2'b01, 32'h0000_0002, 32'hBEEF_0001, 0, 3'b001);
    tick(); exp_cnt++;
    checks++;
    if (dataWr !== 32'hFFFF_BEEF) begin
      errors++;
      $display("FAIL lh: data=%h, want ffffbeef", dataWr);
    end
    // lhu with aluRes[0]=1: low address bit ignored
    set_in(1, 5'd6, 1, 2'b01, 32'h0000_0003, 32'hBEEF_0001, 0, 3'b101);
    tick(); exp_cnt++;
    checks++;
    if (dataWr !== 32'h0000_BEEF) begin
      errors++;
      $display("FAIL lhu_odd: data=%h, want 0000beef", dataWr);
    end
    // lbu byte 2
    set_in(1, 5'd6, 1, 2'b01, 32'h0000_1002, 32'h80FF_1234, 0, 3'b100);
    tick(); exp_cnt++;
    checks++;
    if (dataWr !== 32'h0000_00FF) begin
      errors++;
      $display("FAIL lbu: data=%h, want 000000ff", dataWr);
    end
    // lh low half, negative
    set_in(1, 5'd6, 1, 2'b01, 32'h0000_0000, 32'h0001_8001, 0, 3'b001);
    tick(); exp_cnt++;
    checks++;
    if (dataWr !== 32'hFFFF_8001) begin
      errors++;
      $display("FAIL lh_lo: data=%h, want ffff8001", dataWr);
    end
    // unknown funct3 -> full word
    set_in(1, 5'd6, 1, 2'b01, 32'h0000_0001, 32'h80FF_1234, 0, 3'b111);
    tick(); exp_cnt++;
    checks++;
    if (dataWr !== 32'h80FF_1234) begin
      errors++;
      $display("FAIL ld_other: data=%h, want 80ff1234", dataWr);
    end
  endtask

  task automatic test_sel();
    set_in(1, 5'd0, 1, 2'b10, 32'h0, 32'h0, 32'h0000_0104, 0);
    tick(); exp_cnt++;
    checks++;
    if (ruWr !== 1'b0 || dataWr !== 32'h104) begin
      errors++;
      $display("FAIL pc4_x0: ruWr=%b data=%h, want 0 00000104", ruWr, dataWr);
    end
    set_in(1, 5'd1, 1, 2'b10, 32'h0, 32'h0, 32'h0000_0104, 0);
    tick(); exp_cnt++;
    checks++;
    if (ruWr !== 1'b1 || dataWr !== 32'h104 || rd !== 5'd1) begin
      errors++;
      $display("FAIL pc4: ruWr=%b data=%h rd=%0d, want 1 00000104 1", ruWr, dataWr, rd);
    end
    set_in(1, 5'd3, 1, 2'b00, 32'h1234_5678, 32'h0, 32'h4, 0);
    tick(); exp_cnt++;
    checks++;
    if (ruWr !== 1'b1 || dataWr !== 32'h1234_5678) begin
      errors++;
      $display("FAIL alu: ruWr=%b data=%h, want 1 12345678", ruWr, dataWr);
    end
    set_in(1, 5'd3, 1, 2'b11, 32'h1234_5678, 32'h5, 32'h4, 0);
    tick(); exp_cnt++;
    checks++;
    if (ruWr !== 1'b0 || dataWr !== 32'h0 || instret !== CW'(exp_cnt)) begin
      errors++;
      $display("FAIL rsv: ruWr=%b data=%h cnt=%0d, want 0 00000000 %0d",
               ruWr, dataWr, instret, exp_cnt);
    end
    // regWr=0 suppresses the write
    set_in(1, 5'd3, 0, 2'b00, 32'h1, 32'h0, 32'h0, 0);
    tick(); exp_cnt++;
    checks++;
    if (ruWr !== 1'b0) begin
      errors++;
      $display("FAIL nowr: ruWr=%b, want 0", ruWr);
    end
  endtask

  task automatic test_stall();
    set_in(1, 5'd7, 1, 2'b00, 32'h0000_A5A5, 0, 0, 0);
    tick(); exp_cnt++;
    set_in(1, 5'd8, 1, 2'b00, 32'h0, 0, 0, 0);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (ruWr !== 1'b1 || rd !== 5'd7 || dataWr !== 32'hA5A5 || instret !== CW'(exp_cnt)) begin
        errors++;
        $display("FAIL stall%0d: ruWr=%b rd=%0d data=%h cnt=%0d, want 1 7 0000a5a5 %0d",
                 i, ruWr, rd, dataWr, instret, exp_cnt);
      end
    end
    stall = 0; in_valid = 0;
    tick(); exp_cnt++;
    checks++;
    if (ruWr !== 1'b0 || instret !== CW'(exp_cnt)) begin
      errors++;
      $display("FAIL stall_rel: ruWr=%b cnt=%0d, want 0 %0d", ruWr, instret, exp_cnt);
    end
  endtask

  task automatic test_flush();
    set_in(1, 5'd10, 1, 2'b00, 32'h0000_0AAA, 0, 0, 0);
    tick();                       // latch was a bubble: no retire
    stall = 1; flush = 1;
    tick(); exp_cnt++;
    checks++;
    if (ruWr !== 1'b0 || instret !== CW'(exp_cnt)) begin
      errors++;
      $display("FAIL flush: ruWr=%b cnt=%0d, want 0 %0d", ruWr, instret, exp_cnt);
    end
    stall = 0; flush = 0; in_valid = 0;
    tick();
    checks++;
    if (instret !== CW'(exp_cnt)) begin
      errors++;
      $display("FAIL flush_bubble: cnt=%0d, want %0d", instret, exp_cnt);
    end
  endtask

  task automatic test_fwd_rst();
    rs1 = 5'd9; rs2 = 5'd9;
    set_in(1, 5'd9, 1, 2'b00, 32'h0000_0099, 0, 0, 0);
    tick();
    checks++;
    if (fwdA !== 1'b1 || fwdB !== 1'b1 || ruWr !== 1'b1) begin
      errors++;
      $display("FAIL fwd_both: fwdA=%b fwdB=%b ruWr=%b, want 1 1 1", fwdA, fwdB, ruWr);
    end
    rs2 = 5'd4;
    #1;
    checks++;
    if (fwdA !== 1'b1 || fwdB !== 1'b0) begin
      errors++;
      $display("FAIL fwd_a: fwdA=%b fwdB=%b, want 1 0", fwdA, fwdB);
    end
    rst = 1; rs1 = 5'd0; rs2 = 5'd0;
    set_in(1, 5'd9, 1, 2'b00, 32'h0000_0055, 0, 0, 0);
    tick();
    rst = 0; in_valid = 0;
    checks++;
    if ({rd, dataWr, ruWr, fwdA, fwdB} !== 40'h0 || instret !== '0) begin
      errors++;
      $display("FAIL rst_mid: rd=%0d data=%h ruWr=%b fwd=%b%b cnt=%0d, want all 0",
               rd, dataWr, ruWr, fwdA, fwdB, instret);
    end
  endtask

  task automatic test_wrap();
    // latch empty after reset; edge k (k>=2) retires the instruction from edge k-1
    set_in(1, 5'd2, 1, 2'b00, 32'h1, 0, 0, 0);
    for (int k = 1; k <= 17; k++) begin
      tick();
      if (k == 16) begin
        checks++;
        if (instret !== 4'hF) begin
          errors++;
          $display("FAIL wrap_max: cnt=%0d, want 15", instret);
        end
      end
    end
    checks++;
    if (instret !== 4'h0) begin
      errors++;
      $display("FAIL wrap_zero: cnt=%0d, want 0", instret);
    end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_sel();
    test_stall();
    test_flush();
    test_fwd_rst();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
